// File: rtl/cra_wide_seq_pkg.sv
// -----------------------------------------------------------------------------
// cra_wide_seq_pkg
// Shared definitions for the sequenced wide adder:
//   CRA_CHUNK     - width of the shared ripple-carry slice adder
//   ST_*          - FSM state encodings (IDLE / RUN / DONE)
//   msb_carry_in  - recovers the carry into a slice MSB from a, b and sum bits
// -----------------------------------------------------------------------------
package cra_wide_seq_pkg;

  localparam int CRA_CHUNK = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // sum = a ^ b ^ carry_in at any bit, so the carry into that bit is a ^ b ^ sum.
  function automatic logic msb_carry_in(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
    return a_msb ^ b_msb ^ s_msb;
  endfunction

endpackage

// File: rtl/cra_wide_seq_cra16.sv
// -----------------------------------------------------------------------------
// cra16
// Purely combinational 16-bit ripple-carry adder used as the shared slice adder.
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry into bit 0
//   sum   out 16  a + b + cin (mod 2^16)
//   cout  out 1   carry out of bit 15
// -----------------------------------------------------------------------------
module cra16
  import cra_wide_seq_pkg::*;
(
  input  logic [CRA_CHUNK-1:0] a,
  input  logic [CRA_CHUNK-1:0] b,
  input  logic                 cin,
  output logic [CRA_CHUNK-1:0] sum,
  output logic                 cout
);

  // Ripple chain: the carry lives in a block-local variable so the chain is
  // evaluated bit by bit in one pass.
  always_comb begin
    logic v_c;
    v_c  = cin;
    sum  = {CRA_CHUNK{1'b0}};
    for (int i = 0; i < CRA_CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ v_c;
      v_c    = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
    end
    cout = v_c;
  end

endmodule

// File: rtl/cra_wide_seq.sv
// -----------------------------------------------------------------------------
// cra_wide_seq
// Multi-cycle WIDTH-bit adder computing a + b + cin by running one shared cra16
// over WIDTH/16 slices, least-significant slice first, with the inter-slice
// carry held in a register. Valid/ready handshake on both sides.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block idle and able to take operands
//   a, b       in   WIDTH  operands
//   cin        in   1      carry into slice 0
//   out_valid  out  1      sum/cout/ovf valid
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  a + b + cin mod 2^WIDTH
//   cout       out  1      carry out of the MSB slice
//   ovf        out  1      signed overflow (carry into MSB ^ carry out of MSB)
// WIDTH must be a multiple of 16 and at least 16.
// -----------------------------------------------------------------------------
module cra_wide_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import cra_wide_seq_pkg::*;

  localparam int CHUNK  = CRA_CHUNK;
  localparam int NCHUNK = WIDTH / CHUNK;
  // One spare bit so the index can step past the last slice without wrapping.
  localparam int IDX_W  = $clog2(NCHUNK) + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;
  logic             w_msb_cin;

  // Operand slice mux: pick the slice addressed by the index counter.
  always_comb begin
    w_a_slice = {CHUNK{1'b0}};
    w_b_slice = {CHUNK{1'b0}};
    for (int i = 0; i < NCHUNK; i++) begin
      w_a_slice = (r_idx == IDX_W'(i)) ? r_a[i*CHUNK +: CHUNK] : w_a_slice;
      w_b_slice = (r_idx == IDX_W'(i)) ? r_b[i*CHUNK +: CHUNK] : w_b_slice;
    end
  end

  cra16 u_cra16 (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
  assign w_msb_cin = msb_carry_in(w_a_slice[CHUNK-1], w_b_slice[CHUNK-1],
                                  w_slice_sum[CHUNK-1]);

  // FSM plus all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_idx       <= {IDX_W{1'b0}};
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            // The carry register doubles as the slice-0 carry-in.
            r_carry    <= cin;
            r_idx      <= {IDX_W{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_sum[i*CHUNK +: CHUNK] <= w_slice_sum;
            end
          end
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_cout      <= w_slice_cout;
            r_ovf       <= w_msb_cin ^ w_slice_cout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean idle state.
          r_state     <= ST_IDLE;
          r_idx       <= {IDX_W{1'b0}};
          r_carry     <= 1'b0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
